reg_file_mp: RTL and testbench



---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_mp_scoreboard.sv | 68 ++++++
 rtl/reg_file_mp.sv | 105 ++++++++++
 tb/tb_reg_file_mp.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// ============================================================================
//  Module   : reg_file_pkg
//  Purpose  : Shared constants and types for the multi-port register file.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [XLEN_DEF-1:0] xlen_t;
    typedef logic [4:0]          reg_addr_t;

    // Architectural zero register; never written, never busy.
    localparam reg_addr_t REG_ZERO = '0;

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/reg_file_mp_scoreboard.sv
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Per-register busy tracking. Issue reserves a destination,
//             writeback releases it; a same-cycle reserve beats a release
//             because the new producer supersedes the retiring one.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 1,
    parameter int NRD   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NWR-1:0]                we,
    input  logic [NWR*$clog2(NREGS)-1:0]  wa,
    input  logic                          rsv_en,
    input  logic [$clog2(NREGS)-1:0]      rsv_addr,
    input  logic [NRD*$clog2(NREGS)-1:0]  ra,
    output logic [NRD-1:0]                rd_busy
);

    localparam int AW = $clog2(NREGS);

    // Register 0 has no storage; its busy bit is a constant 0 in busy_vec.
    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_d;
    logic [NREGS-1:0] busy_vec;

    assign busy_vec = {busy_q, 1'b0};

    // Next busy state: releases first, then the reservation overrides.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (wa[j*AW +: AW] != '0)) begin
                busy_d[wa[j*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Busy state register; reset drops every pending reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Busy lookup for each read port from registered state.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy_vec[ra[i*AW +: AW]];
        end
    end

endmodule : reg_scoreboard

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
//  Module   : reg_file_mp
//  Purpose  : Multi-port integer register file with NRD combinational read
//             ports, NWR write ports (highest port wins on address clash)
//             and a busy scoreboard for hazard detection.
//  Options  : REG_FILE_BYPASS_EN - forward same-cycle write data to reads.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NRD*$clog2(NREGS)-1:0]  ra,
    output logic [NRD*XLEN-1:0]           rd,
    output logic [NRD-1:0]                rd_busy,
    input  logic [NWR-1:0]                we,
    input  logic [NWR*$clog2(NREGS)-1:0]  wa,
    input  logic [NWR*XLEN-1:0]           wd,
    input  logic                          rsv_en,
    input  logic [$clog2(NREGS)-1:0]      rsv_addr
);

    localparam int AW = $clog2(NREGS);

    // Entry 0 is reset and never written, so it is a constant the tools prune.
    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic [NRD-1:0]  sb_busy;

    reg_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wa       (wa),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .ra       (ra),
        .rd_busy  (sb_busy)
    );

    // Next data array: ascending port order lets the highest port win.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (wa[j*AW +: AW] != '0)) begin
                mem_d[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
            end
        end
    end

    // Data array register with synchronous clear.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NREGS; k++) begin
            mem_q[k] <= rst ? '0 : mem_d[k];
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic [NRD-1:0] byp;

    // Read ports with forwarding of this cycle's write data (highest port).
    always_comb begin
        rd  = '0;
        byp = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ra[i*AW +: AW] != '0) begin
                rd[i*XLEN +: XLEN] = mem_q[ra[i*AW +: AW]];
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j*AW +: AW] == ra[i*AW +: AW])) begin
                        rd[i*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
                        byp[i]             = 1'b1;
                    end
                end
            end
        end
        rd_busy = sb_busy & ~byp;
    end
`else
    // Read ports from registered contents only; x0 reads as zero.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ra[i*AW +: AW] != '0) begin
                rd[i*XLEN +: XLEN] = mem_q[ra[i*AW +: AW]];
            end
        end
        rd_busy = sb_busy;
    end
`endif

endmodule : reg_file_mp

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
//  Module   : tb_reg_file_mp
//  Purpose  : Self-checking bench for reg_file_mp (NRD=4, NWR=2) with a
//             queue-based scoreboard and an array-based reference model.
//  Options  : REG_FILE_BYPASS_EN - expectations follow forwarding behaviour.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rd;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    wa;
    logic [NWR*XLEN-1:0]  wd;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_addr;

    always #5 clk = ~clk;

    reg_file_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          passed = 0;

    // Reference state: architectural contents and outstanding reservations.
    logic [31:0] m_mem  [NREGS];
    bit          m_busy [NREGS];

    // Monitor: compare every queued expectation while outputs are stable.
    initial begin
        forever begin
            @(negedge clk);
            while (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                checks++;
                if (rd[e.port*XLEN +: XLEN] === e.data && rd_busy[e.port] === e.busy) begin
                    passed++;
                end else begin
                    $display("FAIL %s port%0d: got rd=%h busy=%b, want rd=%h busy=%b",
                             e.tag, e.port, rd[e.port*XLEN +: XLEN], rd_busy[e.port],
                             e.data, e.busy);
                end
            end
        end
    end

    task automatic idle();
        rst      = 1'b0;
        we       = '0;
        wa       = '0;
        wd       = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2, input int a3);
        ra[0*AW +: AW] = AW'(a0);
        ra[1*AW +: AW] = AW'(a1);
        ra[2*AW +: AW] = AW'(a2);
        ra[3*AW +: AW] = AW'(a3);
    endtask

    task automatic wr(input int port, input int addr, input logic [31:0] data);
        we[port]             = 1'b1;
        wa[port*AW +: AW]    = AW'(addr);
        wd[port*XLEN +: XLEN] = data;
    endtask

    task automatic expect_const(input int port, input logic [31:0] data,
                                input logic busy, input string tag);
        exp_t e;
        e.port = port; e.data = data; e.busy = busy; e.tag = tag;
        expq.push_back(e);
    endtask

    // Queue model expectations for the current inputs, then advance one clock.
    task automatic tick();
        for (int p = 0; p < NRD; p++) begin
            int          a;
            logic [31:0] d;
            logic        b;
            a = int'(ra[p*AW +: AW]);
            d = (a == 0) ? 32'h0 : m_mem[a];
            b = (a == 0) ? 1'b0  : m_busy[a];
`ifdef REG_FILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (a != 0 && we[j] && int'(wa[j*AW +: AW]) == a) begin
                    d = wd[j*XLEN +: XLEN];
                    b = 1'b0;
                end
            end
`endif
            expect_const(p, d, b, "model");
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                m_mem[k]  = 32'h0;
                m_busy[k] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                int a;
                a = int'(wa[j*AW +: AW]);
                if (we[j] && a != 0) begin
                    m_mem[a]  = wd[j*XLEN +: XLEN];
                    m_busy[a] = 1'b0;
                end
            end
            if (rsv_en && rsv_addr != '0) m_busy[int'(rsv_addr)] = 1'b1;
        end
        #1;
    endtask

    initial begin
        for (int k = 0; k < NREGS; k++) begin
            m_mem[k]  = 32'h0;
            m_busy[k] = 1'b0;
        end
        idle();
        set_ra(0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // Reset clear, with a write and reserve ignored during the reset cycle.
        idle(); set_ra(5, 0, 0, 0);
        wr(0, 5, 32'hDEADBEEF);
        tick();
        idle();
        expect_const(0, 32'hDEADBEEF, 1'b0, "x5_written");
        tick();
        rst = 1'b1; wr(1, 5, 32'h00001234); rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        idle();
        expect_const(0, 32'h0, 1'b0, "reset_clear");
        tick();

        // x0 hardwire on every port.
        set_ra(0, 0, 0, 0);
        wr(0, 0, 32'hFFFFFFFF); rsv_en = 1'b1; rsv_addr = 5'd0;
        for (int p = 0; p < NRD; p++) expect_const(p, 32'h0, 1'b0, "x0_same_cycle");
        tick();
        idle();
        for (int p = 0; p < NRD; p++) expect_const(p, 32'h0, 1'b0, "x0_next_cycle");
        tick();

        // Highest write port wins.
        wr(0, 7, 32'h11111111); wr(1, 7, 32'h22222222);
        tick();
        idle(); set_ra(7, 0, 0, 0);
        expect_const(0, 32'h22222222, 1'b0, "write_priority");
        tick();

        // Scoreboard sequence on x9.
        set_ra(9, 0, 0, 0);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        expect_const(0, 32'h0, 1'b1, "rsv_busy");
        tick();
        wr(0, 9, 32'h00001234);
        tick();
        idle();
        expect_const(0, 32'h00001234, 1'b0, "write_release");
        tick();
        wr(1, 9, 32'h00005678); rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        idle();
        expect_const(0, 32'h00005678, 1'b1, "rsv_beats_release");
        tick();

        // Same-cycle read of a reserved register being written.
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        idle(); set_ra(3, 0, 0, 0);
        wr(0, 3, 32'hA5A5A5A5);
`ifdef REG_FILE_BYPASS_EN
        expect_const(0, 32'hA5A5A5A5, 1'b0, "bypass_same_cycle");
`else
        expect_const(0, 32'h0, 1'b1, "no_bypass_same_cycle");
`endif
        tick();
        idle();
        expect_const(0, 32'hA5A5A5A5, 1'b0, "write_next_cycle");
        tick();

        // Multi-read with independent and duplicate addresses.
        wr(0, 1, 32'd1); wr(1, 2, 32'd2);
        tick();
        idle(); wr(0, 3, 32'd3); wr(1, 4, 32'd4);
        tick();
        idle(); set_ra(1, 2, 3, 4);
        for (int p = 0; p < NRD; p++) expect_const(p, 32'(p + 1), 1'b0, "multi_read");
        tick();
        set_ra(4, 4, 1, 2);
        expect_const(0, 32'd4, 1'b0, "dup_read");
        expect_const(1, 32'd4, 1'b0, "dup_read");
        expect_const(2, 32'd1, 1'b0, "dup_read");
        expect_const(3, 32'd2, 1'b0, "dup_read");
        tick();

        // Randomized traffic biased toward a few registers to force collisions.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(63) == 0);
            for (int j = 0; j < NWR; j++) begin
                we[j]                 = $urandom_range(1);
                wa[j*AW +: AW]        = AW'($urandom_range(1) ? $urandom_range(7) : $urandom_range(31));
                wd[j*XLEN +: XLEN]    = $urandom;
            end
            rsv_en   = $urandom_range(1);
            rsv_addr = AW'($urandom_range(1) ? $urandom_range(7) : $urandom_range(31));
            for (int p = 0; p < NRD; p++) begin
                ra[p*AW +: AW] = AW'($urandom_range(1) ? $urandom_range(7) : $urandom_range(31));
            end
            tick();
        end

        idle();
        for (int w = 0; w < 4 && expq.size() > 0; w++) @(negedge clk);
        if (expq.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending, want 0", expq.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_reg_file_mp

`default_nettype wire
